// File: rtl/handshake_slice_pkg.sv
// Shared types for the handshake register slice: per-stage state encoding and stall counter width.
// Feature macro HANDSHAKE_SLICE_STALL_CNT_EN adds a stall_count port to the top level.
// No logic lives here.
package handshake_slice_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } slice_state_t;

    localparam int STALL_CNT_WIDTH = 32;

endpackage

// File: rtl/handshake_register_slice_skid_stage.sv
// One valid/ready skid stage: main register plus skid register, both ports fully registered.
// Latency: 1 cycle in to out when the downstream is ready.
// Backpressure: absorbs one extra beat in the skid register, then drops in_ready_o (a register output).
module skid_stage
    import handshake_slice_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i
);

    slice_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  in_xfer;
    logic                  out_xfer;

    assign in_ready_o  = (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = main_q;

    // Transfers need clk_en, so a frozen stage keeps every register untouched.
    assign in_xfer  = in_valid_i & in_ready_o & clk_en_i;
    assign out_xfer = out_valid_o & out_ready_i & clk_en_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_d  = in_data_i;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_d = in_data_i;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end else if (in_xfer) begin
                    skid_d  = in_data_i;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= RESET_VALUE;
            skid_q  <= RESET_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/handshake_register_slice.sv
// Chain of NUM_STAGES skid stages (0 = wire-through); optional stall_count under HANDSHAKE_SLICE_STALL_CNT_EN.
// Latency: NUM_STAGES cycles, 1 beat/cycle sustained, capacity 2*NUM_STAGES beats.
// Backpressure: data_in_ready is registered per stage; clk_en=0 freezes state and masks both handshakes.
module handshake_register_slice
    import handshake_slice_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_STAGES  = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clk_en,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       data_in_valid,
    output logic                       data_in_ready,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       data_out_valid,
    input  logic                       data_out_ready
`ifdef HANDSHAKE_SLICE_STALL_CNT_EN
    ,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
`endif
);

    generate
        if (NUM_STAGES == 0) begin : g_bypass
            logic unused_bypass;
            assign unused_bypass  = ^{clk, rst};
            assign data_out       = data_in;
            assign data_out_valid = data_in_valid & clk_en;
            assign data_in_ready  = data_out_ready & clk_en;
        end else begin : g_chain
            logic [NUM_STAGES:0][DATA_WIDTH-1:0] dat;
            logic [NUM_STAGES:0]                 vld;
            logic [NUM_STAGES:0]                 rdy;

            assign dat[0]          = data_in;
            assign vld[0]          = data_in_valid;
            assign rdy[NUM_STAGES] = data_out_ready;

            for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
                skid_stage #(
                    .DATA_WIDTH (DATA_WIDTH),
                    .RESET_VALUE(RESET_VALUE)
                ) u_stage (
                    .clk        (clk),
                    .rst        (rst),
                    .clk_en_i   (clk_en),
                    .in_data_i  (dat[i]),
                    .in_valid_i (vld[i]),
                    .in_ready_o (rdy[i]),
                    .out_data_o (dat[i+1]),
                    .out_valid_o(vld[i+1]),
                    .out_ready_i(rdy[i+1])
                );
            end

            // Masking with rst: nothing can be accepted or handed off while state is being cleared.
            assign data_in_ready  = rdy[0] & clk_en & ~rst;
            assign data_out_valid = vld[NUM_STAGES] & clk_en & ~rst;
            assign data_out       = data_out_valid ? dat[NUM_STAGES] : RESET_VALUE;
        end
    endgenerate

`ifdef HANDSHAKE_SLICE_STALL_CNT_EN
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    // data_out_valid already carries clk_en; saturate at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (data_out_valid && !data_out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_handshake_register_slice.sv
// Directed bench for handshake_register_slice: 2-stage slice with RESET_VALUE 'hA5 plus a 0-stage bypass.
// Honours HANDSHAKE_SLICE_STALL_CNT_EN for the stall counter checks.
module tb_handshake_register_slice;

    localparam logic [31:0] RV = 32'hA5;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic [31:0] din;
    logic        din_vld;
    logic        din_rdy;
    logic [31:0] dout;
    logic        dout_vld;
    logic        dout_rdy;

    logic        b_rst;
    logic        b_en;
    logic [31:0] b_din;
    logic        b_vld;
    logic        b_rdy;
    logic [31:0] b_dout;
    logic        b_dout_vld;
    logic        b_dout_rdy;

`ifdef HANDSHAKE_SLICE_STALL_CNT_EN
    logic [31:0] stall;
    logic [31:0] b_stall;
`endif

    int errors = 0;
    int checks = 0;

    handshake_register_slice #(
        .DATA_WIDTH (32),
        .NUM_STAGES (2),
        .RESET_VALUE(RV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .data_in       (din),
        .data_in_valid (din_vld),
        .data_in_ready (din_rdy),
        .data_out      (dout),
        .data_out_valid(dout_vld),
        .data_out_ready(dout_rdy)
`ifdef HANDSHAKE_SLICE_STALL_CNT_EN
        ,
        .stall_count   (stall)
`endif
    );

    handshake_register_slice #(
        .DATA_WIDTH (32),
        .NUM_STAGES (0),
        .RESET_VALUE(RV)
    ) u_bypass (
        .clk           (clk),
        .rst           (b_rst),
        .clk_en        (b_en),
        .data_in       (b_din),
        .data_in_valid (b_vld),
        .data_in_ready (b_rdy),
        .data_out      (b_dout),
        .data_out_valid(b_dout_vld),
        .data_out_ready(b_dout_rdy)
`ifdef HANDSHAKE_SLICE_STALL_CNT_EN
        ,
        .stall_count   (b_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        en;
        logic        vld;
        logic [31:0] dat;
        logic        rdy;
        logic        exp_irdy;
        logic        exp_ovld;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic en, input logic vld, input logic [31:0] dat, input logic rdy,
                       input logic ei, input logic eo, input logic [31:0] ed);
        vec_t v;
        v = '{en, vld, dat, rdy, ei, eo, ed};
        tbl.push_back(v);
    endtask

    task automatic bp(input string name, input logic r, input logic en, input logic [31:0] d,
                      input logic v, input logic rd, input logic [31:0] ed, input logic ev, input logic er);
        b_rst = r; b_en = en; b_din = d; b_vld = v; b_dout_rdy = rd;
        #1;
        chk({name, "_dat"}, b_dout, ed);
        chk({name, "_vld"}, 32'(b_dout_vld), 32'(ev));
        chk({name, "_rdy"}, 32'(b_rdy), 32'(er));
    endtask

    initial begin
        int          nout;
        int          sent;
        int          recv;
        int          stall_m;
        logic        done;
        logic        acc;
        logic        prev_stall;
        logic [31:0] prev_dat;
        logic [31:0] sb[$];
        logic [31:0] exp_head;

        rst = 1'b1; clk_en = 1'b1; din = 32'h77; din_vld = 1'b1; dout_rdy = 1'b1;
        b_rst = 1'b0; b_en = 1'b1; b_din = '0; b_vld = 1'b0; b_dout_rdy = 1'b0;

        // Reset held 3 edges with a valid beat offered: nothing accepted.
        repeat (3) begin
            @(negedge clk); #1;
            chk("rst_in_rdy", 32'(din_rdy), 32'd0);
            chk("rst_out_vld", 32'(dout_vld), 32'd0);
            chk("rst_dout", dout, RV);
        end
        @(negedge clk);
        rst = 1'b0; din_vld = 1'b0;
        #1;
        chk("post_rst_in_rdy", 32'(din_rdy), 32'd1);
        chk("post_rst_out_vld", 32'(dout_vld), 32'd0);
        chk("post_rst_dout", dout, RV);
`ifdef HANDSHAKE_SLICE_STALL_CNT_EN
        chk("post_rst_stall", stall, 32'd0);
`endif

        // Latency and throughput: beat k in at cycle k, out at cycle k+2.
        nout = 0;
        dout_rdy = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            din_vld = (c < 16);
            din     = (c < 16) ? 32'(c) : 32'd0;
            #1;
            if (din_vld) chk("tp_in_rdy", 32'(din_rdy), 32'd1);
            if (dout_vld) begin
                chk("tp_data", dout, 32'(nout));
                chk("tp_cycle", 32'(c), 32'(nout + 2));
                nout++;
            end
        end
        chk("tp_count", 32'(nout), 32'd16);

        // Back-pressure fill/drain, then clk_en freeze with 3 beats held.
        add(1, 1, 32'h1, 0, 1, 0, RV);
        add(1, 1, 32'h2, 0, 1, 0, RV);
        add(1, 1, 32'h3, 0, 1, 1, 32'h1);
        add(1, 1, 32'h4, 0, 1, 1, 32'h1);
        add(1, 1, 32'h5, 0, 0, 1, 32'h1);
        add(1, 1, 32'h5, 1, 0, 1, 32'h1);
        add(1, 1, 32'h5, 1, 0, 1, 32'h2);
        add(1, 1, 32'h5, 1, 1, 1, 32'h3);
        add(1, 0, 32'h0, 1, 1, 1, 32'h4);
        add(1, 0, 32'h0, 1, 1, 1, 32'h5);
        add(1, 0, 32'h0, 1, 1, 0, RV);
        add(1, 1, 32'h10, 0, 1, 0, RV);
        add(1, 1, 32'h11, 0, 1, 0, RV);
        add(1, 1, 32'h12, 0, 1, 1, 32'h10);
        repeat (5) add(0, 1, 32'h13, 1, 0, 0, RV);
        add(1, 1, 32'h13, 1, 1, 1, 32'h10);
        add(1, 0, 32'h0, 1, 0, 1, 32'h11);
        add(1, 0, 32'h0, 1, 1, 1, 32'h12);
        add(1, 0, 32'h0, 1, 1, 1, 32'h13);
        add(1, 0, 32'h0, 1, 1, 0, RV);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            clk_en = tbl[i].en; din_vld = tbl[i].vld; din = tbl[i].dat; dout_rdy = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d_in_rdy", i), 32'(din_rdy), 32'(tbl[i].exp_irdy));
            chk($sformatf("tbl%0d_out_vld", i), 32'(dout_vld), 32'(tbl[i].exp_ovld));
            chk($sformatf("tbl%0d_dout", i), dout, tbl[i].exp_dat);
        end

        // Random valid/ready against a FIFO scoreboard.
        sent = 0; recv = 0; acc = 1'b0; prev_stall = 1'b0; prev_dat = '0;
        din_vld = 1'b0; clk_en = 1'b1;
        for (int c = 0; c < 20000 && recv < 1000; c++) begin
            @(negedge clk);
            if (acc) din_vld = 1'b0;
            if (!din_vld && sent < 1000 && $urandom_range(1, 0) == 1) begin
                din_vld = 1'b1;
                din     = $urandom;
            end
            dout_rdy = ($urandom_range(1, 0) == 1);
            #1;
            if (prev_stall) begin
                chk("rnd_stable_vld", 32'(dout_vld), 32'd1);
                chk("rnd_stable_dat", dout, prev_dat);
            end
            acc = din_vld && din_rdy;
            if (acc) begin
                sb.push_back(din);
                sent++;
            end
            if (dout_vld && dout_rdy) begin
                if (sb.size() == 0) begin
                    chk("rnd_spurious", 32'd1, 32'd0);
                end else begin
                    exp_head = sb.pop_front();
                    chk("rnd_data", dout, exp_head);
                end
                recv++;
            end
            prev_stall = dout_vld && !dout_rdy;
            prev_dat   = dout;
        end
        chk("rnd_count", 32'(recv), 32'd1000);
        chk("rnd_sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-stream with 4 beats held and 7 stalled cycles.
        @(negedge clk);
        rst = 1'b1; din_vld = 1'b0; dout_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sent = 0; stall_m = 0; done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            din_vld = (sent < 4); din = 32'h21 + 32'(sent); dout_rdy = 1'b0;
            #1;
            if (din_vld && din_rdy) sent++;
            if (dout_vld && !dout_rdy) stall_m++;
            if (sent == 4 && stall_m == 7) done = 1'b1;
        end
        @(negedge clk);
        din_vld = 1'b0;
        #1;
        chk("mid_done", 32'(done), 32'd1);
        chk("mid_full_in_rdy", 32'(din_rdy), 32'd0);
        chk("mid_head", dout, 32'h21);
`ifdef HANDSHAKE_SLICE_STALL_CNT_EN
        chk("mid_stall_7", stall, 32'd7);
`endif
        @(negedge clk);
        rst = 1'b1; dout_rdy = 1'b1;
        #1;
        chk("mid_rst_out_vld", 32'(dout_vld), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
`ifdef HANDSHAKE_SLICE_STALL_CNT_EN
        chk("mid_stall_clr", stall, 32'd0);
`endif
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                @(negedge clk); #1;
            end
            chk("mid_no_beat_vld", 32'(dout_vld), 32'd0);
            chk("mid_no_beat_dat", dout, RV);
        end

        // Zero-stage bypass: pure combinational pass-through, rst ignored.
        bp("byp_pass", 0, 1, 32'hDEAD, 1, 1, 32'hDEAD, 1, 1);
        bp("byp_novld", 0, 1, 32'h1234, 0, 1, 32'h1234, 0, 1);
        bp("byp_bp", 0, 1, 32'h5555, 1, 0, 32'h5555, 1, 0);
        bp("byp_frz", 0, 0, 32'hAAAA, 1, 1, 32'hAAAA, 0, 0);
        bp("byp_rst", 1, 1, 32'h0077, 1, 1, 32'h0077, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/handshake_register_slice.md
Name: handshake_register_slice

Overview:
- Parametrised successor to the single-register slice: a chain of NUM_STAGES valid/ready skid-buffer stages between a producer and a consumer.
- Breaks timing on data, valid and ready paths.
- Sustains 1 transfer/cycle and never loses or duplicates data under back-pressure.
- Keeps the team's clk_en freeze and RESET_VALUE semantics.
- Used between compute units and memory/stream interfaces in the accelerator datapath.

Parameters:
- DATA_WIDTH, 32, payload width in bits (>=1).
- NUM_STAGES, 2, number of skid stages in series (>=0; 0 = combinational pass-through).
- RESET_VALUE, 0, value of all payload registers after reset; also driven on data_out while data_out_valid=0.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  global enable; 0 freezes all state.
- data_in  in  DATA_WIDTH  upstream payload.
- data_in_valid  in  1  upstream valid.
- data_in_ready  out  1  slice can accept.
- data_out  out  DATA_WIDTH  downstream payload.
- data_out_valid  out  1  downstream valid.
- data_out_ready  in  1  downstream can accept.

Behaviour:
- Reset value of all stages is EMPTY; main and skid registers = RESET_VALUE.
  - After reset: data_out_valid=0, data_out=RESET_VALUE.
  - data_in_ready=1 from the first cycle after rst deasserts, provided clk_en=1.
- Transfer rule: a beat transfers on a port when valid & ready are both high at a rising clk edge with clk_en=1.
- Stage FSM (per stage; in = upstream side, out = downstream side):
  - EMPTY: in_ready=1, out_valid=0. On in-transfer: load main, go to BUSY.
  - BUSY: in_ready=1, out_valid=1.
    - in-transfer and out-transfer together: main<=in, stay BUSY.
    - out-transfer only: go to EMPTY.
    - in-transfer only: skid<=in, go to FULL.
  - FULL: in_ready=0, out_valid=1.
    - On out-transfer: main<=skid, go to BUSY.
- in_ready of each stage is a register output (from FSM state), so there is no combinational ready path across stages or to data_in_ready.
- Latency: NUM_STAGES cycles from data_in transfer to data_out_valid when downstream is ready.
- Capacity: 2*NUM_STAGES beats.
- Throughput: 1 beat/cycle in steady state.
- Ordering: strictly FIFO. No beat is dropped or duplicated.
- data_out = main register of the last stage while data_out_valid=1, else RESET_VALUE.
- data_out_valid, once asserted, stays high with data_out stable until the transfer (AXI-stream rule). The slice relies on upstream obeying the same rule.
- clk_en=0:
  - No state or register updates.
  - data_in_ready and data_out_valid forced 0 combinationally; data_out = RESET_VALUE.
  - On clk_en returning to 1, the pre-freeze state is resumed unchanged.
- rst has priority over clk_en. rst mid-operation discards all held beats; outputs take reset values the next cycle.
- NUM_STAGES=0: data_out=data_in, data_out_valid=data_in_valid&clk_en, data_in_ready=data_out_ready&clk_en. No registers; rst has no effect.

Optional Feature:
- Macro: HANDSHAKE_SLICE_STALL_CNT_EN.
- Defined: extra port stall_count out 32, a saturating counter.
  - Increments each cycle with clk_en=1 and data_out_valid=1 and data_out_ready=0.
  - Cleared by rst; holds at 32'hFFFF_FFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package handshake_slice_pkg:
  - typedef enum logic [1:0] {EMPTY, BUSY, FULL} slice_state_t.
  - STALL_CNT_WIDTH=32 constant.
- Sub-module skid_stage (DATA_WIDTH, RESET_VALUE): one FSM stage.
- Top level instantiates NUM_STAGES skid_stage in a generate loop; it also holds the clk_en gating, the NUM_STAGES=0 bypass and the optional counter.

Test Plan:
- Reset: rst high 3 cycles with data_in_valid=1 -> data_out_valid=0, data_out=RESET_VALUE (set to 'hA5 for this test), data_in_ready=0 during rst, 1 after.
- Latency/throughput: NUM_STAGES=2, ready=1, stream 0..15 back-to-back -> first beat at data_out 2 cycles after its in-transfer, then 16 consecutive valid cycles, values 0..15 in order.
- Back-pressure: data_out_ready=0 while sending 1,2,3,... -> exactly 4 beats accepted (data_in_ready falls), then ready=1 -> 1,2,3,4 out in order, no gaps after the first.
- Random valid/ready toggling (50%), 1000 beats -> scoreboard matches exactly; data_out stable while valid&!ready.
- clk_en=0 for 5 cycles mid-stream with 3 beats held -> ready/valid low, no transfers; after re-enable same 3 beats emerge in order.
- Reset mid-stream with 4 beats held -> no held beat ever appears on data_out; with HANDSHAKE_SLICE_STALL_CNT_EN, 7 stalled cycles -> stall_count=7, then 0 after rst.
